// File: rtl/shaper_table_writer.sv
// shaper_table_writer: byte-stream loader for a double-banked waveshaper curve,
// committed by a bank swap on an audio strobe, plus the 1-cycle audio lookup.
module shaper_table_writer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [7:0]               cfg_data,
  input  logic                     cfg_last,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_signal,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_signal,
  output logic                     active_bank,
  output logic                     table_loaded,
  output logic                     frame_err,
  input  logic                     err_clr
);
  typedef enum logic [1:0] {IDLE, HI, LO, WAIT_SWAP} state_t;
  state_t r_state, w_next;
  logic r_rdy, r_active, r_loaded, r_err, r_out_valid;
  logic [ADDR_W-1:0] r_ptr;
  logic [7:0] r_msb;
  logic signed [DATA_W-1:0] r_out;
  logic [DATA_W-1:0] r_mem [2**(ADDR_W+1)];
  logic w_acc, w_we, w_err, w_swap;
  logic [ADDR_W-1:0] w_addr;
  // r_rdy keeps cfg_ready low while in reset and for the edge that releases it
  assign cfg_ready    = r_rdy && r_state != WAIT_SWAP;
  assign w_acc        = cfg_valid && cfg_ready;
  assign w_addr       = in_signal[DATA_W-1 -: ADDR_W] + ADDR_W'(2**(ADDR_W-1));
  assign out_valid    = r_out_valid;
  assign out_signal   = r_out;
  assign active_bank  = r_active;
  assign table_loaded = r_loaded;
  assign frame_err    = r_err;
  always_comb begin
    w_next = r_state;
    w_we   = 1'b0;
    w_err  = 1'b0;
    w_swap = 1'b0;
    case (r_state)
      IDLE: if (w_acc) begin
        w_err  = cfg_last;
        w_next = cfg_last ? IDLE : HI;
      end
      HI: if (w_acc) begin
        w_err  = cfg_last;
        w_next = cfg_last ? IDLE : LO;
      end
      LO: if (w_acc) begin
        w_we   = 1'b1;
        w_next = cfg_last ? WAIT_SWAP : HI;
      end
      WAIT_SWAP: if (in_valid) begin
        w_swap = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rdy       <= 1'b0;
      r_ptr       <= '0;
      r_msb       <= '0;
      r_active    <= 1'b0;
      r_loaded    <= 1'b0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
    end else begin
      r_state     <= w_next;
      r_rdy       <= 1'b1;
      if (w_acc && r_state == IDLE) r_ptr <= ADDR_W'(cfg_data);
      else if (w_we) r_ptr <= r_ptr + 1'b1;
      if (w_acc && r_state == HI) r_msb <= cfg_data;
      r_err       <= w_err || (r_err && !err_clr);
      if (w_swap) begin
        r_active <= ~r_active;
        r_loaded <= 1'b1;
      end
      r_out_valid <= in_valid;
      // bank and loaded flag are sampled before a same-edge swap takes effect
      if (in_valid) r_out <= r_loaded ? r_mem[{r_active, w_addr}] : in_signal;
    end
  end
  always_ff @(posedge clk)
    if (w_we) r_mem[{~r_active, r_ptr}] <= DATA_W'({r_msb, cfg_data});
endmodule

// File: tb/tb_shaper_table_writer.sv
// tb_shaper_table_writer: directed checks of load, commit, lookup, errors and reset.
module tb_shaper_table_writer;
  logic clk = 1'b0, rst = 1'b1;
  logic cfg_valid = 1'b0, cfg_last = 1'b0, in_valid = 1'b0, err_clr = 1'b0;
  logic [7:0] cfg_data = '0;
  logic signed [15:0] in_signal = '0;
  logic cfg_ready, out_valid, active_bank, table_loaded, frame_err;
  logic signed [15:0] out_signal;
  int checks = 0, failures = 0;

  shaper_table_writer dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_data(cfg_data), .cfg_last(cfg_last), .in_valid(in_valid),
    .in_signal(in_signal), .out_valid(out_valid), .out_signal(out_signal),
    .active_bank(active_bank), .table_loaded(table_loaded),
    .frame_err(frame_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int n = 0;
    cfg_valid = 1'b1;
    cfg_data  = d;
    cfg_last  = l;
    while (cfg_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cfg_ready_timeout", {31'd0, cfg_ready}, 32'd1);
    @(negedge clk);
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  task automatic sample(input logic [15:0] s, input logic [15:0] exp, input string tag);
    in_valid  = 1'b1;
    in_signal = s;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk(tag, {16'd0, out_signal}, {16'd0, exp});
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    idle(2);
    chk("rst_cfg_ready", {31'd0, cfg_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_signal", {16'd0, out_signal}, 32'd0);
    chk("rst_active_bank", {31'd0, active_bank}, 32'd0);
    chk("rst_table_loaded", {31'd0, table_loaded}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b0;
    idle(1);
    chk("post_rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);

    sample(16'h1234, 16'h1234, "passthrough");
    idle(1);
    chk("out_valid_drop", {31'd0, out_valid}, 32'd0);
    chk("out_signal_hold", {16'd0, out_signal}, 32'h1234);

    // entry k = (k-128)*256: MSB = k ^ 0x80, LSB = 0
    send(8'h00, 1'b0);
    for (int k = 0; k < 256; k++) begin
      send(8'(k) ^ 8'h80, 1'b0);
      send(8'h00, k == 255);
    end
    chk("wait_cfg_ready_low", {31'd0, cfg_ready}, 32'd0);
    idle(20);
    chk("hold_cfg_ready_low", {31'd0, cfg_ready}, 32'd0);
    chk("hold_active_bank", {31'd0, active_bank}, 32'd0);
    chk("hold_table_loaded", {31'd0, table_loaded}, 32'd0);
    sample(16'h4000, 16'h4000, "commit_strobe_old_bank");
    chk("commit_active_bank", {31'd0, active_bank}, 32'd1);
    chk("commit_table_loaded", {31'd0, table_loaded}, 32'd1);
    chk("commit_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    sample(16'h8000, 16'h8000, "lookup_min");
    sample(16'h0000, 16'h0000, "lookup_zero");
    sample(16'h7F00, 16'h7F00, "lookup_max");
    sample(16'h1234, 16'h1200, "lookup_mid");

    send(8'h10, 1'b0);
    send(8'hAB, 1'b1);
    chk("odd_frame_err", {31'd0, frame_err}, 32'd1);
    chk("odd_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    sample(16'h8000, 16'h8000, "odd_no_swap_lookup");
    chk("odd_no_swap_bank", {31'd0, active_bank}, 32'd1);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    chk("err_clr", {31'd0, frame_err}, 32'd0);
    err_clr = 1'b1;
    send(8'h05, 1'b1);
    err_clr = 1'b0;
    chk("err_set_wins", {31'd0, frame_err}, 32'd1);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    chk("err_clr2", {31'd0, frame_err}, 32'd0);

    send(8'hFF, 1'b0);
    send(8'h11, 1'b0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h22, 1'b1);
    sample(16'h8000, 16'h8000, "wrap_commit_old_bank");
    chk("wrap_active_bank", {31'd0, active_bank}, 32'd0);
    sample(16'h7F00, 16'h1111, "wrap_addr255");
    sample(16'h8000, 16'h2222, "wrap_addr0");

    send(8'h00, 1'b0);
    for (int k = 0; k < 5; k++) begin
      send(8'h3C, 1'b0);
      send(8'hC3, 1'b0);
    end
    rst = 1'b1;
    idle(2);
    chk("midrst_table_loaded", {31'd0, table_loaded}, 32'd0);
    chk("midrst_active_bank", {31'd0, active_bank}, 32'd0);
    chk("midrst_cfg_ready", {31'd0, cfg_ready}, 32'd0);
    rst = 1'b0;
    idle(1);
    sample(16'h5555, 16'h5555, "midrst_passthrough");

    // entry k = {k, ~k}
    send(8'h00, 1'b0);
    for (int k = 0; k < 256; k++) begin
      send(8'(k), 1'b0);
      send(~8'(k), k == 255);
    end
    chk("reload_cfg_ready_low", {31'd0, cfg_ready}, 32'd0);
    sample(16'h6666, 16'h6666, "reload_commit_passthrough");
    chk("reload_active_bank", {31'd0, active_bank}, 32'd1);
    chk("reload_table_loaded", {31'd0, table_loaded}, 32'd1);
    sample(16'h8000, 16'h00FF, "reload_addr0");
    sample(16'h0100, 16'h817E, "reload_addr129");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
